// File: rtl/gauss_result_collector.sv
// ============================================================================
// gauss_result_collector
//
// Purpose:
//   Rejoin point of the two Gauss functional units. Results from FU0 and FU1
//   are pushed into a small shared FIFO (up to two pushes per cycle, FU0
//   always ahead of FU1). One entry per cycle is drained into a running-sum
//   accumulator and an entry counter. Once both units report their last
//   element and nothing is buffered or in flight, the block raises done.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 4)
//   ACC_W  accumulator width in bits (>= 17)
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   preset  in   asynchronous active-low reset
//   start   in   one-cycle pulse; clears acc/count/ovf/done/FIFO, enters RUN
//   res0    in   [15:0] FU0 result
//   valid0  in   res0 valid this cycle
//   last0   in   level; FU0 has produced its final result
//   res1    in   [15:0] FU1 result
//   valid1  in   res1 valid this cycle
//   last1   in   level; FU1 has produced its final result
//   stall   out  FIFO cannot guarantee room for two pushes
//   acc     out  [ACC_W-1:0] running sum of drained results
//   count   out  [7:0] number of drained results, wraps at 256
//   ovf     out  sticky; a push was dropped (or the sum saturated)
//   done    out  level; job complete
//
// Build option:
//   COLLECTOR_SATURATE_EN  when defined, acc clamps at 2^ACC_W-1 and the
//                          first clamped addition sets ovf. When undefined
//                          (default), acc wraps modulo 2^ACC_W and wrap does
//                          not touch ovf.
// ============================================================================
module gauss_result_collector #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             start,
    input  logic [15:0]      res0,
    input  logic             valid0,
    input  logic             last0,
    input  logic [15:0]      res1,
    input  logic             valid1,
    input  logic             last1,
    output logic             stall,
    output logic [ACC_W-1:0] acc,
    output logic [7:0]       count,
    output logic             ovf,
    output logic             done
);

    // Pointer width indexes the storage; occupancy needs one extra bit so
    // that a completely full FIFO (occ == DEPTH) is representable.
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [15:0]    mem [DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [OW-1:0]  occ;

    logic           in_run;
    logic           pop;
    logic [15:0]    head;
    logic [OW-1:0]  free;
    logic           push0;
    logic           push1;
    logic           drop;
    logic [PW-1:0]  slot1;
    logic [OW-1:0]  occ_next;
    logic [PW-1:0]  wp_next;
    logic [ACC_W-1:0] acc_next;
    logic           sat;
    logic           finish_job;

`ifdef COLLECTOR_SATURATE_EN
    logic [ACC_W:0] sum_ext;
`endif

    // stall is derived from the registered occupancy only, so it lags the
    // occupancy change by one cycle; FUs sample it before issuing.
    assign stall = (occ > OW'(DEPTH - 2));

    // Push/pop decisions for the current cycle. The slot freed by a pop in
    // this cycle is available to the pushes in the same cycle. When only a
    // single slot is free, FU0 wins and FU1's result is dropped.
    always_comb begin
        in_run   = (state == RUN);
        pop      = in_run && (occ != '0);
        head     = mem[rp];
        free     = OW'(DEPTH) - occ + {{(OW-1){1'b0}}, pop};
        push0    = in_run && valid0 && (free != '0);
        push1    = in_run && valid1 && (free > {{(OW-1){1'b0}}, push0});
        drop     = in_run && ((valid0 && !push0) || (valid1 && !push1));
        slot1    = wp + PW'(push0);
        wp_next  = wp + PW'(push0) + PW'(push1);
        occ_next = occ + {{(OW-1){1'b0}}, push0} + {{(OW-1){1'b0}}, push1}
                       - {{(OW-1){1'b0}}, pop};
        finish_job = in_run && last0 && last1 && (occ == '0) && !valid0 && !valid1;
    end

    // Accumulator update for a popped head. The saturating build detects the
    // carry out of the widened sum and clamps to all ones.
    always_comb begin
`ifdef COLLECTOR_SATURATE_EN
        sum_ext = {1'b0, acc} + {{(ACC_W-15){1'b0}}, head};
        if (sum_ext[ACC_W]) begin
            acc_next = '1;
            sat      = pop;
        end else begin
            acc_next = sum_ext[ACC_W-1:0];
            sat      = 1'b0;
        end
`else
        acc_next = acc + {{(ACC_W-16){1'b0}}, head};
        sat      = 1'b0;
`endif
    end

    // FIFO storage. No reset is needed: an entry is only ever read after it
    // has been written, and reset/start simply rewind the pointers.
    always_ff @(posedge clk) begin
        if (!start) begin
            if (push0) begin
                mem[wp] <= res0;
            end
            if (push1) begin
                mem[slot1] <= res1;
            end
        end
    end

    // Control FSM with all outputs registered. start beats every other event
    // in its cycle, including pushes and pops, and always lands in RUN with a
    // clean FIFO and cleared result registers.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state <= IDLE;
            wp    <= '0;
            rp    <= '0;
            occ   <= '0;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            state <= RUN;
            wp    <= '0;
            rp    <= '0;
            occ   <= '0;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                RUN: begin
                    wp  <= wp_next;
                    occ <= occ_next;
                    if (pop) begin
                        rp    <= rp + PW'(1);
                        acc   <= acc_next;
                        count <= count + 8'd1;
                    end
                    if (drop || sat) begin
                        ovf <= 1'b1;
                    end
                    if (finish_job) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // Results arriving after completion are lost.
                    if (valid0 || valid1) begin
                        ovf <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_result_collector.sv
// ============================================================================
// tb_gauss_result_collector
//
// Directed bench for gauss_result_collector (DEPTH=4, ACC_W=17). A table of
// one-cycle input vectors with hand-computed outputs covers the main flows;
// hand-written sequences cover reset, asynchronous reset mid-job and the
// behaviour after completion.
// ============================================================================
module tb_gauss_result_collector;

    localparam int DEPTH = 4;
    localparam int ACC_W = 17;

    logic             clk;
    logic             preset;
    logic             start;
    logic [15:0]      res0;
    logic             valid0;
    logic             last0;
    logic [15:0]      res1;
    logic             valid1;
    logic             last1;
    logic             stall;
    logic [ACC_W-1:0] acc;
    logic [7:0]       count;
    logic             ovf;
    logic             done;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic             st;
        logic             v0;
        logic [15:0]      r0;
        logic             v1;
        logic [15:0]      r1;
        logic             lst;
        logic [ACC_W-1:0] e_acc;
        logic [7:0]       e_cnt;
        logic             e_ovf;
        logic             e_done;
        logic             e_stall;
    } vec_t;

    vec_t vecs[$];

    gauss_result_collector #(
        .DEPTH(DEPTH),
        .ACC_W(ACC_W)
    ) dut (
        .clk    (clk),
        .preset (preset),
        .start  (start),
        .res0   (res0),
        .valid0 (valid0),
        .last0  (last0),
        .res1   (res1),
        .valid1 (valid1),
        .last1  (last1),
        .stall  (stall),
        .acc    (acc),
        .count  (count),
        .ovf    (ovf),
        .done   (done)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic st, input logic v0, input logic [15:0] r0,
                                input logic v1, input logic [15:0] r1, input logic lst,
                                input logic [ACC_W-1:0] e_acc, input logic [7:0] e_cnt,
                                input logic e_ovf, input logic e_done, input logic e_stall);
        vec_t v;
        v.st = st; v.v0 = v0; v.r0 = r0; v.v1 = v1; v.r1 = r1; v.lst = lst;
        v.e_acc = e_acc; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_done = e_done;
        v.e_stall = e_stall;
        return v;
    endfunction

    // Inputs change 1 time unit after the rising edge and hold for the cycle.
    task automatic applyStimulus(input logic st, input logic v0, input logic [15:0] r0,
                                 input logic v1, input logic [15:0] r1, input logic lst);
        start  = st;
        valid0 = v0;
        res0   = r0;
        valid1 = v1;
        res1   = r1;
        last0  = lst;
        last1  = lst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [ACC_W-1:0] e_acc,
                            input logic [7:0] e_cnt, input logic e_ovf,
                            input logic e_done, input logic e_stall);
        checkOutput({tag, " acc"},   32'(acc),   32'(e_acc));
        checkOutput({tag, " count"}, 32'(count), 32'(e_cnt));
        checkOutput({tag, " ovf"},   32'(ovf),   32'(e_ovf));
        checkOutput({tag, " done"},  32'(done),  32'(e_done));
        checkOutput({tag, " stall"}, 32'(stall), 32'(e_stall));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // ------------------------------------------------------------------
        // Vector table: inputs held for one cycle, outputs checked after edge.
        // ------------------------------------------------------------------
        // Single pushes 1,3,6,10, then last: acc 20, count 4, done after empty
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3,  0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  4, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 6,  0, 0, 0,  4, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 10, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 10, 0, 0, 0, 10, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 1, 20, 4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 1, 20, 4, 0, 1, 0));
        // Dual push 15/21 on empty FIFO: 15 popped first, then 21
        vecs.push_back(mk(1, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15, 1, 21, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 15, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 36, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 36, 2, 0, 0, 0));
        // Sustained dual pushes ignoring stall; 8 is dropped (one free slot)
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 4, 0,  1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 5, 1, 6, 0,  3, 2, 0, 0, 1));
        vecs.push_back(mk(0, 1, 7, 1, 8, 0,  6, 3, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10, 4, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 15, 5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 21, 6, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 28, 7, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 28, 7, 1, 0, 0));
        // 0xFFFF three times into a 17-bit accumulator
        vecs.push_back(mk(1, 0, 0,       0, 0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'hFFFF, 0, 0, 0, 0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'hFFFF, 0, 0, 0, 17'hFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'hFFFF, 0, 0, 0, 17'h1FFFE, 2, 0, 0, 0));
`ifdef COLLECTOR_SATURATE_EN
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 17'h1FFFF, 3, 1, 0, 0));
`else
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 17'h0FFFD, 3, 0, 0, 0));
`endif

        // ------------------------------------------------------------------
        // Power-on reset
        // ------------------------------------------------------------------
        applyStimulus(0, 0, 0, 0, 0, 0);
        preset = 1'b0;
        #12;
        checkAll("reset", 0, 0, 0, 0, 0);
        preset = 1'b1;
        tick();
        // IDLE ignores pushes entirely: nothing stored, nothing dropped
        applyStimulus(0, 1, 16'd7, 1, 16'd8, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkAll("idle", 0, 0, 0, 0, 0);

        // ------------------------------------------------------------------
        // Table-driven vectors
        // ------------------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].st, vecs[i].v0, vecs[i].r0,
                          vecs[i].v1, vecs[i].r1, vecs[i].lst);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_cnt,
                     vecs[i].e_ovf, vecs[i].e_done, vecs[i].e_stall);
        end

        // ------------------------------------------------------------------
        // Asynchronous reset with entries buffered, no clock edge involved
        // ------------------------------------------------------------------
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 16'd2, 1, 16'd3, 0);
        tick();
        applyStimulus(0, 1, 16'd4, 1, 16'd5, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("prereset", 2, 1, 0, 0, 1);
        #2;
        preset = 1'b0;
        #1;
        checkAll("async_reset", 0, 0, 0, 0, 0);
        #1;
        preset = 1'b1;
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 16'd5, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkAll("after_reset", 5, 1, 0, 0, 0);

        // ------------------------------------------------------------------
        // Completion, late push in DONE, then restart
        // ------------------------------------------------------------------
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();
        checkAll("done", 5, 1, 0, 1, 0);
        applyStimulus(0, 1, 16'd9, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();
        checkAll("done_push", 5, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        tick();
        checkAll("restart", 0, 0, 0, 0, 0);
        // Back in RUN: a push is accepted and drained
        applyStimulus(0, 1, 16'd4, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkAll("run_again", 4, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
